// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, line/frame counters, sync decode and
// a pin register stage that aligns colour and sync on the same clk edge.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] horizCount,
  output logic [9:0] vertCount,
  output logic       videoOn,
  output logic       pixelTick,
  output logic       frameTick,
  input  logic [3:0] redIn,
  input  logic [3:0] greenIn,
  input  logic [3:0] blueIn,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       vgaHsync,
  output logic       vgaVsync
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [COL_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             div_end_c, pixel_tick_c, h_end_c, v_end_c, video_on_c;
  logic             hsync_act_c, vsync_act_c;

  // Divider, counter advance, and pin-stage decode from the current counts
  always_comb begin
    div_end_c    = (div_q == DIV_W'(CLK_DIV - 1));
    pixel_tick_c = div_end_c && !reset;
    h_end_c      = (h_q == CNT_W'(H_TOTAL - 1));
    v_end_c      = (v_q == CNT_W'(V_TOTAL - 1));
    video_on_c   = (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));
    hsync_act_c  = (h_q >= CNT_W'(H_SYNC_START)) && (h_q < CNT_W'(H_SYNC_END));
    vsync_act_c  = (v_q >= CNT_W'(V_SYNC_START)) && (v_q < CNT_W'(V_SYNC_END));

    div_d = div_end_c ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (pixel_tick_c) begin
      h_d = h_end_c ? '0 : h_q + CNT_W'(1);
      if (h_end_c) begin
        v_d = v_end_c ? '0 : v_q + CNT_W'(1);
      end
    end

    red_d   = video_on_c ? redIn   : '0;
    green_d = video_on_c ? greenIn : '0;
    blue_d  = video_on_c ? blueIn  : '0;
    hsync_d = ~hsync_act_c;
    vsync_d = ~vsync_act_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign horizCount = h_q;
  assign vertCount  = v_q;
  assign videoOn    = video_on_c;
  assign pixelTick  = pixel_tick_c;
  assign frameTick  = pixel_tick_c && h_end_c && v_end_c;
  assign vgaRed     = red_q;
  assign vgaGreen   = green_q;
  assign vgaBlue    = blue_q;
  assign vgaHsync   = hsync_q;
  assign vgaVsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (small raster /4, small raster /1,
// full 640x480 /4) compared every clk against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int N_CYC = 12000;
  localparam int DIV_P [NI] = '{4, 1, 4};
  localparam int HV_P  [NI] = '{20, 20, 640};
  localparam int HF_P  [NI] = '{3, 3, 16};
  localparam int HS_P  [NI] = '{5, 5, 96};
  localparam int HB_P  [NI] = '{4, 4, 48};
  localparam int VV_P  [NI] = '{12, 12, 480};
  localparam int VF_P  [NI] = '{2, 2, 10};
  localparam int VS_P  [NI] = '{2, 2, 2};
  localparam int VB_P  [NI] = '{3, 3, 33};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] r_in, g_in, b_in;

  logic [9:0] hc [NI];
  logic [9:0] vc [NI];
  logic       von [NI], ptk [NI], ftk [NI], hs [NI], vs [NI];
  logic [3:0] pr [NI], pg [NI], pb [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV(DIV_P[g]), .H_VISIBLE(HV_P[g]), .H_FRONT(HF_P[g]),
      .H_SYNC(HS_P[g]), .H_BACK(HB_P[g]), .V_VISIBLE(VV_P[g]),
      .V_FRONT(VF_P[g]), .V_SYNC(VS_P[g]), .V_BACK(VB_P[g])
    ) u_dut (
      .clk(clk), .reset(reset),
      .horizCount(hc[g]), .vertCount(vc[g]), .videoOn(von[g]),
      .pixelTick(ptk[g]), .frameTick(ftk[g]),
      .redIn(r_in), .greenIn(g_in), .blueIn(b_in),
      .vgaRed(pr[g]), .vgaGreen(pg[g]), .vgaBlue(pb[g]),
      .vgaHsync(hs[g]), .vgaVsync(vs[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: k = clk edges since reset release; pixel index = k / CLK_DIV
  int k;
  int exp_r [NI], exp_g [NI], exp_b [NI], exp_hs [NI], exp_vs [NI];

  function automatic int htot(input int i);
    return HV_P[i] + HF_P[i] + HS_P[i] + HB_P[i];
  endfunction

  function automatic int vtot(input int i);
    return VV_P[i] + VF_P[i] + VS_P[i] + VB_P[i];
  endfunction

  initial begin
    reset = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    k = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      reset = (cyc < 3) || (cyc == 5003) || (cyc == 9001) ||
              ($urandom_range(0, 3999) == 0);
      if (cyc >= 1000 && cyc < 3000) begin
        r_in = 4'hF; g_in = 4'h8; b_in = 4'h2;
      end else begin
        r_in = 4'($urandom); g_in = 4'($urandom); b_in = 4'($urandom);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        int pix, h, v, ht, vt;
        bit tick, vis;
        ht   = htot(i);
        vt   = vtot(i);
        pix  = (k / DIV_P[i]) % (ht * vt);
        h    = pix % ht;
        v    = pix / ht;
        tick = !reset && ((k % DIV_P[i]) == DIV_P[i] - 1);
        vis  = (h < HV_P[i]) && (v < VV_P[i]);
        if (cyc > 0) begin
          check($sformatf("d%0d c%0d hcount", i, cyc), 32'(hc[i]), 32'(h));
          check($sformatf("d%0d c%0d vcount", i, cyc), 32'(vc[i]), 32'(v));
          check($sformatf("d%0d c%0d video_on", i, cyc), 32'(von[i]), 32'(vis));
          check($sformatf("d%0d c%0d pixel_tick", i, cyc), 32'(ptk[i]), 32'(tick));
          check($sformatf("d%0d c%0d frame_tick", i, cyc), 32'(ftk[i]),
                32'(tick && (pix == ht * vt - 1)));
          check($sformatf("d%0d c%0d red", i, cyc), 32'(pr[i]), 32'(exp_r[i]));
          check($sformatf("d%0d c%0d green", i, cyc), 32'(pg[i]), 32'(exp_g[i]));
          check($sformatf("d%0d c%0d blue", i, cyc), 32'(pb[i]), 32'(exp_b[i]));
          check($sformatf("d%0d c%0d hsync", i, cyc), 32'(hs[i]), 32'(exp_hs[i]));
          check($sformatf("d%0d c%0d vsync", i, cyc), 32'(vs[i]), 32'(exp_vs[i]));
        end
        // Pin values the coming edge will load
        if (reset) begin
          exp_r[i] = 0; exp_g[i] = 0; exp_b[i] = 0;
          exp_hs[i] = 1; exp_vs[i] = 1;
        end else begin
          exp_r[i]  = vis ? int'(r_in) : 0;
          exp_g[i]  = vis ? int'(g_in) : 0;
          exp_b[i]  = vis ? int'(b_in) : 0;
          exp_hs[i] = (h >= HV_P[i] + HF_P[i] && h < HV_P[i] + HF_P[i] + HS_P[i]) ? 0 : 1;
          exp_vs[i] = (v >= VV_P[i] + VF_P[i] && v < VV_P[i] + VF_P[i] + VS_P[i]) ? 0 : 1;
        end
      end
      k = reset ? 0 : k + 1;
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
